// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and flag helper for the registered ALU.
// The first five opcode values keep the legacy combinational ALU codes.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SR  = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd5;
  localparam logic [3:0] OP_SL  = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BCD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Signed overflow: operands agree in sign but the sum does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb ~^ b_msb) & (a_msb ^ s_msb);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between the control unit, the ALU and the
// register file. The ALU uses the slave view; the requester uses master.
interface alu_seq_if #(parameter int DATA_W = 8);

  logic              alu_valid_in;
  logic              alu_ready_out;
  logic [3:0]        alu_control;
  logic              alu_decimal;
  logic [DATA_W-1:0] alu_AI;
  logic [DATA_W-1:0] alu_BI;
  logic              alu_carry_in;
  logic              alu_valid_out;
  logic              alu_ready_in;
  logic [DATA_W-1:0] alu_Y;
  logic              alu_carry_out;
  logic              alu_overflow;
  logic              alu_negative;
  logic              alu_zero;

  modport master (
    output alu_valid_in, alu_control, alu_decimal, alu_AI, alu_BI, alu_carry_in, alu_ready_in,
    input  alu_ready_out, alu_valid_out, alu_Y, alu_carry_out, alu_overflow, alu_negative, alu_zero
  );

  modport slave (
    input  alu_valid_in, alu_control, alu_decimal, alu_AI, alu_BI, alu_carry_in, alu_ready_in,
    output alu_ready_out, alu_valid_out, alu_Y, alu_carry_out, alu_overflow, alu_negative, alu_zero
  );

endinterface

// File: rtl/alu_seq_bcd_digit.sv
// One-nibble 6502-style decimal add/subtract. Non-BCD digits (A-F) are not
// screened; they simply go through the same correction arithmetic.
module alu_seq_bcd_digit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  input  logic       sub,
  output logic [3:0] digit,
  output logic       carry
);

  logic [4:0] sum_s;
  logic [4:0] diff_s;

  assign sum_s  = {1'b0, a} + {1'b0, b} + {4'b0000, c};
  // For subtract, c is the not-borrow from the previous digit.
  assign diff_s = {1'b0, a} - {1'b0, b} - {4'b0000, ~c};

  // Digit correction for add (excess over 9) or subtract (negative result).
  always_comb begin
    digit = 4'd0;
    carry = 1'b0;
    if (sub) begin
      if (diff_s[4]) begin
        digit = diff_s[3:0] - 4'd6;
        carry = 1'b0;
      end else begin
        digit = diff_s[3:0];
        carry = 1'b1;
      end
    end else begin
      if (sum_s > 5'd9) begin
        digit = sum_s[3:0] + 4'd6;
        carry = 1'b1;
      end else begin
        digit = sum_s[3:0];
        carry = 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with N/Z/C/V flags and digit-serial BCD add/subtract,
// fronted by valid/ready on both the request and result sides.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic     clk,
  input  logic     resetn,
  alu_seq_if.slave bus
);

  localparam int NIBBLES = DATA_W / 4;
  localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NIBBLES - 1);

  state_t            state_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [DATA_W-1:0] a_r, b_r, y_r;
  logic              sub_r, dc_r;
  logic              c_r, v_r, n_r, z_r;

  logic              accept_s, bcd_req_s;
  logic [DATA_W-1:0] beff_s, y_bin_s, y_bcd_s;
  logic [DATA_W:0]   sum_s;
  logic              c_bin_s, v_bin_s;
  logic [CNT_W+1:0]  digit_idx_s;
  logic [3:0]        a_nib_s, b_nib_s, dig_s;
  logic              dig_c_s;

  // Ready is held low while reset is asserted even though the state reads IDLE.
  assign bus.alu_ready_out = resetn &
                             ((state_r == ST_IDLE) | ((state_r == ST_DONE) & bus.alu_ready_in));
  assign accept_s  = bus.alu_valid_in & bus.alu_ready_out;
  assign bcd_req_s = bus.alu_decimal &
                     ((bus.alu_control == OP_ADD) | (bus.alu_control == OP_SUB));

  assign bus.alu_valid_out = (state_r == ST_DONE);
  assign bus.alu_Y         = y_r;
  assign bus.alu_carry_out = c_r;
  assign bus.alu_overflow  = v_r;
  assign bus.alu_negative  = n_r;
  assign bus.alu_zero      = z_r;

  // Single-cycle binary result; V also serves decimal ops from the same sum.
  always_comb begin
    beff_s  = (bus.alu_control == OP_SUB) ? ~bus.alu_BI : bus.alu_BI;
    sum_s   = {1'b0, bus.alu_AI} + {1'b0, beff_s} + {{DATA_W{1'b0}}, bus.alu_carry_in};
    y_bin_s = bus.alu_AI;
    c_bin_s = 1'b0;
    v_bin_s = 1'b0;
    case (bus.alu_control)
      OP_ADD, OP_SUB: begin
        y_bin_s = sum_s[DATA_W-1:0];
        c_bin_s = sum_s[DATA_W];
        v_bin_s = add_ovf(bus.alu_AI[DATA_W-1], beff_s[DATA_W-1], sum_s[DATA_W-1]);
      end
      OP_SR: begin
        y_bin_s = {bus.alu_carry_in, bus.alu_AI[DATA_W-1:1]};
        c_bin_s = bus.alu_AI[0];
      end
      OP_SL: begin
        y_bin_s = {bus.alu_AI[DATA_W-2:0], bus.alu_carry_in};
        c_bin_s = bus.alu_AI[DATA_W-1];
      end
      OP_AND:  y_bin_s = bus.alu_AI & bus.alu_BI;
      OP_OR:   y_bin_s = bus.alu_AI | bus.alu_BI;
      OP_XOR:  y_bin_s = bus.alu_AI ^ bus.alu_BI;
      default: y_bin_s = bus.alu_AI;
    endcase
  end

  assign digit_idx_s = {cnt_r, 2'b00};
  assign a_nib_s     = a_r[digit_idx_s +: 4];
  assign b_nib_s     = b_r[digit_idx_s +: 4];

  alu_seq_bcd_digit u_digit (
    .a     (a_nib_s),
    .b     (b_nib_s),
    .c     (dc_r),
    .sub   (sub_r),
    .digit (dig_s),
    .carry (dig_c_s)
  );

  // Result word with the current decimal digit merged in.
  always_comb begin
    y_bcd_s = y_r;
    y_bcd_s[digit_idx_s +: 4] = dig_s;
  end

  // Control FSM together with the operand, result and flag registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      y_r     <= '0;
      sub_r   <= 1'b0;
      dc_r    <= 1'b0;
      c_r     <= 1'b0;
      v_r     <= 1'b0;
      n_r     <= 1'b0;
      z_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (accept_s) begin
            v_r <= v_bin_s;
            if (bcd_req_s) begin
              a_r     <= bus.alu_AI;
              b_r     <= bus.alu_BI;
              sub_r   <= (bus.alu_control == OP_SUB);
              dc_r    <= bus.alu_carry_in;
              cnt_r   <= '0;
              state_r <= ST_BCD;
            end else begin
              y_r     <= y_bin_s;
              c_r     <= c_bin_s;
              n_r     <= y_bin_s[DATA_W-1];
              z_r     <= (y_bin_s == '0);
              state_r <= ST_DONE;
            end
          end else if ((state_r == ST_DONE) && bus.alu_ready_in) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= state_r;
          end
        end
        ST_BCD: begin
          y_r  <= y_bcd_s;
          dc_r <= dig_c_s;
          if (cnt_r == LAST_DIGIT) begin
            c_r     <= dig_c_s;
            n_r     <= y_bcd_s[DATA_W-1];
            z_r     <= (y_bcd_s == '0);
            state_r <= ST_DONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: 8-bit instance for binary/decimal/backpressure
// behaviour, 16-bit instance for 4-digit decimal and mid-operation reset.
module tb_alu_seq;

  logic clk;
  logic resetn8;
  logic resetn16;
  int   n_cmp;
  int   n_err;

  alu_seq_if #(.DATA_W(8))  bus8 ();
  alu_seq_if #(.DATA_W(16)) bus16 ();

  alu_seq #(.DATA_W(8)) u_dut8 (
    .clk    (clk),
    .resetn (resetn8),
    .bus    (bus8.slave)
  );

  alu_seq #(.DATA_W(16)) u_dut16 (
    .clk    (clk),
    .resetn (resetn16),
    .bus    (bus16.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req8(input logic [3:0] op, input logic dec, input logic [7:0] a,
                      input logic [7:0] b, input logic cin);
    bus8.alu_valid_in = 1'b1;
    bus8.alu_control  = op;
    bus8.alu_decimal  = dec;
    bus8.alu_AI       = a;
    bus8.alu_BI       = b;
    bus8.alu_carry_in = cin;
  endtask

  task automatic flags8(input string tag, input logic [7:0] y, input logic c,
                        input logic v, input logic n, input logic z);
    check({tag, "_valid"}, 32'(bus8.alu_valid_out), 32'd1);
    check({tag, "_Y"},     32'(bus8.alu_Y), 32'(y));
    check({tag, "_C"},     32'(bus8.alu_carry_out), 32'(c));
    check({tag, "_V"},     32'(bus8.alu_overflow), 32'(v));
    check({tag, "_N"},     32'(bus8.alu_negative), 32'(n));
    check({tag, "_Z"},     32'(bus8.alu_zero), 32'(z));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    resetn8  = 1'b0;
    resetn16 = 1'b0;
    bus8.alu_valid_in  = 1'b0;
    bus8.alu_control   = 4'd0;
    bus8.alu_decimal   = 1'b0;
    bus8.alu_AI        = 8'h00;
    bus8.alu_BI        = 8'h00;
    bus8.alu_carry_in  = 1'b0;
    bus8.alu_ready_in  = 1'b0;
    bus16.alu_valid_in = 1'b0;
    bus16.alu_control  = 4'd0;
    bus16.alu_decimal  = 1'b0;
    bus16.alu_AI       = 16'h0000;
    bus16.alu_BI       = 16'h0000;
    bus16.alu_carry_in = 1'b0;
    bus16.alu_ready_in = 1'b0;

    // Reset state
    tick();
    tick();
    check("rst_ready", 32'(bus8.alu_ready_out), 32'd0);
    check("rst_valid", 32'(bus8.alu_valid_out), 32'd0);
    check("rst_Y",     32'(bus8.alu_Y), 32'h0);
    check("rst_flags", 32'({bus8.alu_carry_out, bus8.alu_overflow, bus8.alu_negative, bus8.alu_zero}), 32'h0);
    resetn8  = 1'b1;
    resetn16 = 1'b1;
    #1;
    check("post_rst_ready", 32'(bus8.alu_ready_out), 32'd1);

    // Binary ADD 0x50+0x50
    req8(4'd0, 1'b0, 8'h50, 8'h50, 1'b0);
    tick();
    bus8.alu_valid_in = 1'b0;
    flags8("add", 8'hA0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Backpressure: held in DONE for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", 32'(bus8.alu_valid_out), 32'd1);
      check("bp_ready", 32'(bus8.alu_ready_out), 32'd0);
      check("bp_Y",     32'(bus8.alu_Y), 32'hA0);
      check("bp_flags", 32'({bus8.alu_carry_out, bus8.alu_overflow, bus8.alu_negative, bus8.alu_zero}), 32'b0110);
    end

    // Release together with a new SUB request
    bus8.alu_ready_in = 1'b1;
    req8(4'd5, 1'b0, 8'h00, 8'h01, 1'b1);
    #1;
    check("done_ready", 32'(bus8.alu_ready_out), 32'd1);
    tick();
    flags8("sub", 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);

    // Back-to-back SR
    req8(4'd1, 1'b0, 8'h81, 8'h00, 1'b1);
    tick();
    flags8("sr", 8'hC0, 1'b1, 1'b0, 1'b1, 1'b0);

    // Decimal ADD 58+46+1 = 105
    req8(4'd0, 1'b1, 8'h58, 8'h46, 1'b1);
    tick();
    bus8.alu_valid_in = 1'b0;
    check("dadd_lat0", 32'(bus8.alu_valid_out), 32'd0);
    tick();
    check("dadd_lat1", 32'(bus8.alu_valid_out), 32'd0);
    tick();
    flags8("dadd", 8'h05, 1'b1, 1'b1, 1'b0, 1'b0);

    // Decimal SUB 46-12
    req8(4'd5, 1'b1, 8'h46, 8'h12, 1'b1);
    tick();
    bus8.alu_valid_in = 1'b0;
    check("dsub_lat0", 32'(bus8.alu_valid_out), 32'd0);
    tick();
    tick();
    flags8("dsub", 8'h34, 1'b1, 1'b0, 1'b0, 1'b0);

    // Undefined opcode passes A through
    req8(4'hF, 1'b0, 8'h3C, 8'hFF, 1'b1);
    tick();
    bus8.alu_valid_in = 1'b0;
    flags8("undef", 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("idle_valid", 32'(bus8.alu_valid_out), 32'd0);
    check("idle_ready", 32'(bus8.alu_ready_out), 32'd1);

    // 16-bit decimal ADD 9999+0001
    bus16.alu_ready_in = 1'b1;
    bus16.alu_valid_in = 1'b1;
    bus16.alu_control  = 4'd0;
    bus16.alu_decimal  = 1'b1;
    bus16.alu_AI       = 16'h9999;
    bus16.alu_BI       = 16'h0001;
    bus16.alu_carry_in = 1'b0;
    tick();
    bus16.alu_valid_in = 1'b0;
    tick();
    tick();
    tick();
    check("d16_lat3", 32'(bus16.alu_valid_out), 32'd0);
    tick();
    check("d16_valid", 32'(bus16.alu_valid_out), 32'd1);
    check("d16_Y",     32'(bus16.alu_Y), 32'h0000);
    check("d16_C",     32'(bus16.alu_carry_out), 32'd1);
    check("d16_Z",     32'(bus16.alu_zero), 32'd1);
    check("d16_N",     32'(bus16.alu_negative), 32'd0);
    check("d16_V",     32'(bus16.alu_overflow), 32'd0);
    tick();
    check("d16_idle", 32'(bus16.alu_valid_out), 32'd0);

    // Repeat, aborted by reset during the second BCD cycle
    bus16.alu_valid_in = 1'b1;
    tick();
    bus16.alu_valid_in = 1'b0;
    tick();
    #2;
    resetn16 = 1'b0;
    #1;
    check("abort_valid", 32'(bus16.alu_valid_out), 32'd0);
    check("abort_Y",     32'(bus16.alu_Y), 32'h0);
    check("abort_ready", 32'(bus16.alu_ready_out), 32'd0);
    @(negedge clk);
    resetn16 = 1'b1;
    #1;
    check("abort_idle_ready", 32'(bus16.alu_ready_out), 32'd1);
    tick();
    tick();
    check("abort_no_result", 32'(bus16.alu_valid_out), 32'd0);
    check("abort_Y_hold",    32'(bus16.alu_Y), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
